// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// Turns a dual-port RAM macro (active-low selects, registered read port) into
// a valid/ready stream FIFO. RAM reads are prefetched into a 2-entry output
// buffer so the downstream side can take one word per cycle.
//
// Ports
//   CLK, RSTN           clock, asynchronous active-low reset
//   CLR                 synchronous flush
//   IN_VALID/READY/DATA upstream stream
//   OUT_VALID/READY/DATA downstream stream (head of output buffer)
//   COUNT               words held: RAM + in-flight read + output buffer
//   RAM_D/WA/WCSN/WEN   RAM write port
//   RAM_RA/RCSN/Q       RAM read port (Q valid the cycle after a read)
module dpram_fifo_ctrl #(
   parameter int WORDS  = 16,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CLR,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [WIDTH-1:0]  IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WIDTH-1:0]  OUT_DATA,
   output logic [ADDR_W+1:0] COUNT,
   output logic [WIDTH-1:0]  RAM_D,
   output logic [ADDR_W-1:0] RAM_WA,
   output logic [ADDR_W-1:0] RAM_RA,
   output logic              RAM_WCSN,
   output logic              RAM_WEN,
   output logic              RAM_RCSN,
   input  logic [WIDTH-1:0]  RAM_Q
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(WORDS);

   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W:0]   ram_cnt;
   logic              rd_pend;
   logic [1:0]        obuf_cnt;
   logic [WIDTH-1:0]  obuf0, obuf1;

   logic              push, pop, rd;
   logic [2:0]        occ;
   logic [1:0]        cnt_after_pop;
   logic [ADDR_W:0]   ram_cnt_nxt;
   logic [1:0]        obuf_cnt_nxt;
   logic [WIDTH-1:0]  obuf0_nxt, obuf1_nxt;

   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   // RSTN gating keeps the RAM deselected and upstream stalled during reset.
   assign IN_READY  = RSTN & ~CLR & (ram_cnt < DEPTH);
   assign push      = IN_VALID & IN_READY;
   assign OUT_VALID = (obuf_cnt != 2'd0);
   assign pop       = OUT_VALID & OUT_READY;

   // Read only when the buffer slot is guaranteed free by the time Q arrives.
   assign occ = {1'b0, obuf_cnt} + {2'b00, rd_pend};
   assign rd  = RSTN & ~CLR & (ram_cnt != '0) & (occ < (3'd2 + {2'b00, pop}));

   assign RAM_D    = IN_DATA;
   assign RAM_WA   = wptr;
   assign RAM_RA   = rptr;
   assign RAM_WCSN = ~push;
   assign RAM_WEN  = ~push;
   assign RAM_RCSN = ~rd;

   assign OUT_DATA = obuf0;
   assign COUNT    = {1'b0, ram_cnt}
                   + {{(ADDR_W+1){1'b0}}, rd_pend}
                   + {{ADDR_W{1'b0}}, obuf_cnt};

   always_comb begin
      ram_cnt_nxt = ram_cnt;
      case ({push, rd})
         2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
         2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
         default: ram_cnt_nxt = ram_cnt;
      endcase
   end

   // Shift on pop first, then the arriving RAM word lands at the tail.
   always_comb begin
      cnt_after_pop = obuf_cnt - {1'b0, pop};
      obuf0_nxt     = pop ? obuf1 : obuf0;
      obuf1_nxt     = obuf1;
      if (rd_pend) begin
         if (cnt_after_pop == 2'd0) obuf0_nxt = RAM_Q;
         else                       obuf1_nxt = RAM_Q;
      end
      obuf_cnt_nxt = cnt_after_pop + {1'b0, rd_pend};
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         rd_pend  <= 1'b0;
         obuf_cnt <= 2'd0;
         obuf0    <= '0;
         obuf1    <= '0;
      end else if (CLR) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         rd_pend  <= 1'b0;
         obuf_cnt <= 2'd0;
         obuf0    <= '0;
         obuf1    <= '0;
      end else begin
         if (push) wptr <= next_ptr(wptr);
         if (rd)   rptr <= next_ptr(rptr);
         ram_cnt  <= ram_cnt_nxt;
         rd_pend  <= rd;
         obuf_cnt <= obuf_cnt_nxt;
         obuf0    <= obuf0_nxt;
         obuf1    <= obuf1_nxt;
      end
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

   localparam int WORDS  = 16;
   localparam int WIDTH  = 16;
   localparam int ADDR_W = 4;

   logic              CLK = 1'b0;
   logic              RSTN = 1'b0;
   logic              CLR = 1'b0;
   logic              IN_VALID = 1'b0;
   logic              IN_READY;
   logic [WIDTH-1:0]  IN_DATA = '0;
   logic              OUT_VALID;
   logic              OUT_READY = 1'b0;
   logic [WIDTH-1:0]  OUT_DATA;
   logic [ADDR_W+1:0] COUNT;
   logic [WIDTH-1:0]  RAM_D;
   logic [ADDR_W-1:0] RAM_WA;
   logic [ADDR_W-1:0] RAM_RA;
   logic              RAM_WCSN;
   logic              RAM_WEN;
   logic              RAM_RCSN;
   logic [WIDTH-1:0]  RAM_Q;

   dpram_fifo_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RSTN(RSTN), .CLR(CLR),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .COUNT(COUNT),
      .RAM_D(RAM_D), .RAM_WA(RAM_WA), .RAM_RA(RAM_RA),
      .RAM_WCSN(RAM_WCSN), .RAM_WEN(RAM_WEN), .RAM_RCSN(RAM_RCSN),
      .RAM_Q(RAM_Q)
   );

   always #5 CLK = ~CLK;

   // Behavioural RAM macro: registered read port, write on WCSN=WEN=0.
   logic [WIDTH-1:0] mem [WORDS];
   always @(posedge CLK) begin
      if (!RAM_WCSN && !RAM_WEN) mem[RAM_WA] <= RAM_D;
      if (!RAM_RCSN) RAM_Q <= mem[RAM_RA];
   end

   int tests = 0;
   int fails = 0;
   logic [WIDTH-1:0] sb[$];
   bit streaming = 1'b0;
   int wraps = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: samples at the falling edge.
   initial begin
      logic             prev_stall;
      logic [WIDTH-1:0] prev_data;
      logic [WIDTH-1:0] exp_word;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge CLK);
         check("count_vs_model", 32'(COUNT), 32'(sb.size()));
         if (!RAM_RCSN && !RAM_WCSN) begin
            tests++;
            if (RAM_RA == RAM_WA) begin
               fails++;
               $display("FAIL collision: RA %0h equals WA %0h at %0t", RAM_RA, RAM_WA, $time);
            end
         end
         if (prev_stall) begin
            check("stall_valid", 32'(OUT_VALID), 32'd1);
            check("stall_data", 32'(OUT_DATA), 32'(prev_data));
         end
         if (OUT_VALID && OUT_READY) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_pop: got %0h expected no word at %0t", OUT_DATA, $time);
            end else begin
               tests--;
               exp_word = sb.pop_front();
               check("out_data", 32'(OUT_DATA), 32'(exp_word));
            end
         end
         if (CLR) sb.delete();
         if (IN_VALID && IN_READY) sb.push_back(IN_DATA);
         if (streaming && !RAM_WCSN && RAM_WA == ADDR_W'(WORDS - 1)) wraps++;
         prev_stall = RSTN && OUT_VALID && !OUT_READY && !CLR;
         prev_data  = OUT_DATA;
      end
   end

   task automatic push_word(input logic [WIDTH-1:0] d);
      bit ok;
      ok = 1'b0;
      IN_DATA  = d;
      IN_VALID = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         if (IN_READY) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: got no IN_READY expected accept of %0h", d);
      end
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit               acc;
      bit               seen;
      logic [WIDTH-1:0] d;

      // Reset / idle
      RSTN = 1'b0;
      IN_VALID = 1'b1;
      IN_DATA = 16'h5555;
      repeat (3) begin
         @(negedge CLK);
         check("rst_wcsn", 32'(RAM_WCSN), 32'd1);
         check("rst_wen", 32'(RAM_WEN), 32'd1);
         check("rst_rcsn", 32'(RAM_RCSN), 32'd1);
         check("rst_in_ready", 32'(IN_READY), 32'd0);
         check("rst_count", 32'(COUNT), 32'd0);
         check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      end
      @(posedge CLK);
      #1 RSTN = 1'b1;
      IN_DATA = 16'h0001;
      IN_VALID = 1'b1;
      @(posedge CLK);            // edge n: first push
      #1 IN_VALID = 1'b0;
      @(negedge CLK);
      check("lat_after_n", 32'(OUT_VALID), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      check("lat_after_n1", 32'(OUT_VALID), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      check("lat_after_n2_valid", 32'(OUT_VALID), 32'd1);
      check("lat_after_n2_data", 32'(OUT_DATA), 32'h0001);
      @(posedge CLK);
      #1 OUT_READY = 1'b1;
      @(posedge CLK);
      #1 OUT_READY = 1'b0;

      // Fill to full with downstream stalled
      for (int i = 0; i < 18; i++) push_word(WIDTH'(16'h0100 + i));
      repeat (3) @(posedge CLK);
      #1 IN_DATA = 16'h0112;
      IN_VALID = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         check("full_in_ready", 32'(IN_READY), 32'd0);
         check("full_count", 32'(COUNT), 32'd18);
         check("full_wcsn", 32'(RAM_WCSN), 32'd1);
         check("full_out_valid", 32'(OUT_VALID), 32'd1);
      end

      // Drain: 18 words back to back
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge CLK);
         check("drain_no_gap", 32'(OUT_VALID), 32'd1);
      end
      repeat (3) begin
         @(negedge CLK);
         check("drain_count", 32'(COUNT), 32'd0);
         check("drain_rcsn", 32'(RAM_RCSN), 32'd1);
      end

      // Streaming with wrap
      @(posedge CLK);
      #1 streaming = 1'b1;
      d = '0;
      IN_DATA = d;
      IN_VALID = 1'b1;
      OUT_READY = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         acc = IN_READY;
         if (i >= 3) check("stream_no_bubble", 32'(OUT_VALID), 32'd1);
         @(posedge CLK);
         #1;
         if (acc) begin
            d = d + 1'b1;
            IN_DATA = d;
         end
      end
      IN_VALID = 1'b0;
      streaming = 1'b0;
      repeat (8) @(posedge CLK);
      tests++;
      if (wraps < 5) begin
         fails++;
         $display("FAIL stream_wraps: got %0d expected at least 5", wraps);
      end

      // Random backpressure
      repeat (2000) begin
         @(posedge CLK);
         #1 IN_VALID = 1'($urandom_range(0, 1));
         OUT_READY = 1'($urandom_range(0, 1));
         IN_DATA = WIDTH'($urandom);
      end
      #0 IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      repeat (40) @(posedge CLK);
      #1;

      // Flush with a read in flight
      OUT_READY = 1'b0;
      for (int i = 0; i < 8; i++) push_word(WIDTH'(16'h0200 + i));
      repeat (4) @(posedge CLK);
      #1 OUT_READY = 1'b1;       // one pop launches a refill read
      @(posedge CLK);
      #1 OUT_READY = 1'b0;
      CLR = 1'b1;
      @(negedge CLK);
      check("flush_pre_count", 32'(COUNT), 32'd7);
      check("flush_in_ready", 32'(IN_READY), 32'd0);
      check("flush_rcsn", 32'(RAM_RCSN), 32'd1);
      @(posedge CLK);
      #1 CLR = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         check("flush_count", 32'(COUNT), 32'd0);
         check("flush_out_valid", 32'(OUT_VALID), 32'd0);
      end
      @(posedge CLK);
      #1;
      push_word(16'hBEEF);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (OUT_VALID) begin
            seen = 1'b1;
            break;
         end
      end
      check("flush_first_valid", 32'(seen), 32'd1);
      check("flush_first_data", 32'(OUT_DATA), 32'hBEEF);
      @(posedge CLK);
      #1 OUT_READY = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
